// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and default width for the vending timer
package vend_pkg;

  localparam int VEND_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } vend_state_e;

endpackage

// File: rtl/slow_tick_sync.sv
// rtl/slow_tick_sync.sv - synchronises the divider MSB and turns its rising edges into one-cycle ticks
module slow_tick_sync
  import vend_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic slow,
  output logic s_sync,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;
  logic                   rise_q;

  // rise_q is an extra stage so tick lands SYNC_STAGES+1 edges after slow is first captured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
      rise_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow};
      s_prev <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~s_prev;
      tick   <= rise_q;
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - tick-count timeout timer with blink enable for the vending controller
module vend_timer
  import vend_pkg::*;
#(
  parameter int WIDTH       = VEND_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining,
  output logic             blink
);

  vend_state_e      state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             s_sync;
  logic             tick;

  slow_tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .slow   (slow),
    .s_sync (s_sync),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // cancel beats both start (in IDLE) and a coincident tick (in RUN)
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    busy    = 1'b0;
    done    = 1'b0;
    blink   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          rem_d   = load_val;
          state_d = (load_val == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        blink = s_sync;
        if (cancel) begin
          rem_d   = '0;
          state_d = ST_IDLE;
        end else if (tick) begin
          if (rem_q <= WIDTH'(1)) begin
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            rem_d = rem_q - WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        rem_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign remaining = rem_q;

endmodule

// File: tb/tb_vend_timer.sv
// tb/tb_vend_timer.sv - randomized self-checking bench for vend_timer against a tick-history reference model
module tb_vend_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         slow = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         cancel = 1'b0;
  logic         busy, done, blink;
  logic [W-1:0] remaining;

  int errors = 0;
  int checks = 0;

  vend_timer #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .slow      (slow),
    .start     (start),
    .load_val  (load_val),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  // Reference model: m_hist[i] is slow as captured i edges ago; a tick is seen
  // 3 edges after the first high capture; m_phase 0=idle 1=counting 2=expired
  logic [4:0]   m_hist;
  logic         m_tick;
  int           m_phase;
  logic [W-1:0] m_rem;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hist  = '0;
      m_tick  = 1'b0;
      m_phase = 0;
      m_rem   = '0;
    end else begin
      if (m_phase == 2) m_phase = 0;
      else if (m_phase == 0) begin
        if (start && !cancel) begin
          m_rem   = load_val;
          m_phase = (load_val == 0) ? 2 : 1;
        end
      end else begin
        if (cancel) begin
          m_phase = 0;
          m_rem   = 0;
        end else if (m_tick && m_rem > 0) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_phase = 2;
        end
      end
      m_hist = {m_hist[3:0], slow};
      m_tick = m_hist[3] & ~m_hist[4];
    end
  end

  logic [W+2:0] got_v, exp_v;
  assign got_v = {busy, done, blink, remaining};
  assign exp_v = {m_phase == 1, m_phase == 2, (m_phase == 1) & m_hist[1], m_rem};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    checks++;
    if (got_v !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=0", got_v);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (got_v !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=0", i, got_v);
      end
    end
  endtask

  task automatic test_count3();
    int seq[$];
    logic [W-1:0] last;
    int ndone;
    seq = {};
    last = 0;
    ndone = 0;
    start = 1'b1;
    load_val = 3;
    for (int i = 0; i < 90; i++) begin
      cyc();
      start = 1'b0;
      slow = ((i / 8) % 2) == 1;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL count3_model cyc=%0d got=%h exp=%h", i, got_v, exp_v);
      end
      if (remaining != last) begin
        seq.push_back(int'(remaining));
        last = remaining;
      end
      if (done) begin
        ndone++;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL count3_busy_at_done got=%b exp=0", busy);
        end
      end
    end
    checks++;
    if (seq.size() != 4 || seq[0] != 3 || seq[1] != 2 || seq[2] != 1 || seq[3] != 0) begin
      errors++;
      $display("FAIL count3_sequence got_len=%0d exp sequence 3,2,1,0", seq.size());
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL count3_done_pulses got=%0d exp=1", ndone);
    end
    slow = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic test_cancel();
    int n;
    int ndone;
    bit hit;
    n = 0;
    ndone = 0;
    hit = 0;
    start = 1'b1;
    load_val = 5;
    while (n < 200 && !hit) begin
      cyc();
      start = 1'b0;
      slow = ((n / 8) % 2) == 1;
      n++;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL cancel_model cyc=%0d got=%h exp=%h", n, got_v, exp_v);
      end
      if (remaining == 3 && busy) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL cancel_wait timeout remaining=%0d exp=3", remaining);
    end
    slow = 1'b1;
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    checks++;
    if ({busy, remaining, blink} !== {1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL cancel_state got busy=%b rem=%0d blink=%b exp 0/0/0", busy, remaining, blink);
    end
    for (int i = 0; i < 40; i++) begin
      cyc();
      slow = ((i / 8) % 2) == 0;
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_no_done got done_pulses=%0d busy=%b exp 0/0", ndone, busy);
    end
    slow = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic test_zero_load();
    start = 1'b1;
    load_val = 0;
    cyc();
    start = 1'b0;
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b exp 1/0", done, busy);
    end
    cyc();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL zero_after got done=%b busy=%b exp 0/0", done, busy);
    end
  endtask

  task automatic test_start_cancel_retrigger();
    start = 1'b1;
    cancel = 1'b1;
    load_val = 4;
    cyc();
    start = 1'b0;
    cancel = 1'b0;
    checks++;
    if ({busy, done, remaining} !== {1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL start_cancel got busy=%b done=%b rem=%0d exp 0/0/0", busy, done, remaining);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if ({busy, remaining} !== {1'b1, 8'd4}) begin
      errors++;
      $display("FAIL start_load got busy=%b rem=%0d exp 1/4", busy, remaining);
    end
    start = 1'b1;
    load_val = 9;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if ({busy, remaining} !== {1'b1, 8'd4}) begin
      errors++;
      $display("FAIL retrigger got busy=%b rem=%0d exp 1/4", busy, remaining);
    end
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic test_reset_mid();
    int n;
    bit hit;
    int lat;
    n = 0;
    hit = 0;
    lat = -1;
    start = 1'b1;
    load_val = 4;
    while (n < 200 && !hit) begin
      cyc();
      start = 1'b0;
      slow = ((n / 8) % 2) == 1;
      n++;
      if (remaining == 2 && busy && slow) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_wait timeout remaining=%0d exp=2", remaining);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (got_v !== '0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=0", got_v);
    end
    slow = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_no_done got done=%b busy=%b exp 0/0", done, busy);
    end
    repeat (4) cyc();
    start = 1'b1;
    load_val = 3;
    cyc();
    start = 1'b0;
    repeat (6) cyc();
    slow = 1'b1;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      cyc();
      if (remaining == 2) lat = i;
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL tick_latency got edge=%0d exp=5", lat);
    end
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    slow = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic test_random();
    int half;
    int cnt;
    half = 3;
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (cnt >= half) begin
        slow = ~slow;
        cnt = 0;
        half = $urandom_range(2, 9);
      end
      cnt++;
      start = ($urandom_range(0, 3) == 0);
      load_val = W'($urandom_range(0, 6));
      cancel = ($urandom_range(0, 24) == 0);
      cyc();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, got_v, exp_v);
      end
    end
    start = 1'b0;
    cancel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count3();
    test_cancel();
    test_zero_load();
    test_start_cancel_retrigger();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
